// File: rtl/turn_executor_if.sv
// ============================================================================
// turn_executor_if : command handshake between the driving FSM and executor
// Rev 1.0
// ============================================================================
`default_nettype none

interface turn_executor_if;
   logic       cmd_valid;
   logic [3:0] cmd;
   logic       around;
   logic       cmd_ready;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       err;

   modport master (
      output cmd_valid, cmd, around,
      input  cmd_ready, busy, done, aborted, err
   );

   modport slave (
      input  cmd_valid, cmd, around,
      output cmd_ready, busy, done, aborted, err
   );
endinterface

`default_nettype wire

// File: rtl/turn_executor.sv
// ============================================================================
// turn_executor : executes one timed wheel command, then pulses done/aborted
// Rev 1.0
// ============================================================================
`default_nettype none

module turn_executor #(
   parameter int TICK_CYCLES = 2000000,
   parameter int TURN_TICKS  = 200,
   parameter int UTURN_TICKS = 400,
   parameter int FWD_TICKS   = 50
) (
   input  wire logic       sys_clk,
   input  wire logic       rst,
   input  wire logic       power,
   turn_executor_if.slave  cmd_if,
   output logic [1:0]      wheel_l,
   output logic [1:0]      wheel_r
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   localparam logic [PW-1:0] c_presc_last = PW'(TICK_CYCLES - 1);
   localparam logic [10:0]   c_turn_ticks  = 11'(TURN_TICKS);
   localparam logic [10:0]   c_uturn_ticks = 11'(UTURN_TICKS);
   localparam logic [10:0]   c_fwd_ticks   = 11'(FWD_TICKS);

   localparam logic [3:0] c_cmd_stop  = 4'b0000;
   localparam logic [3:0] c_cmd_fwd   = 4'b0001;
   localparam logic [3:0] c_cmd_left  = 4'b0100;
   localparam logic [3:0] c_cmd_right = 4'b1000;

   localparam logic [1:0] c_wh_stop = 2'b00;
   localparam logic [1:0] c_wh_fwd  = 2'b01;
   localparam logic [1:0] c_wh_rev  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TURN = 2'd1,
      S_FWD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [10:0]   r_ticks;
   logic [10:0]   r_dur;
   logic          r_busy;
   logic          r_done;
   logic          r_aborted;
   logic          r_err;
   logic [1:0]    r_wheel_l;
   logic [1:0]    r_wheel_r;

   logic          w_ready;
   logic          w_accept;
   logic          w_tick;
   logic [10:0]   w_ticks_nxt;

   assign w_ready     = (r_state == S_IDLE) && power && !rst;
   assign w_accept    = cmd_if.cmd_valid && w_ready;
   assign w_tick      = (r_presc == c_presc_last);
   assign w_ticks_nxt = r_ticks + 11'd1;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_ticks   <= '0;
         r_dur     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_err     <= 1'b0;
         r_wheel_l <= c_wh_stop;
         r_wheel_r <= c_wh_stop;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_presc <= '0;
                  r_ticks <= '0;
                  case (cmd_if.cmd)
                     c_cmd_left: begin
                        r_state   <= S_TURN;
                        r_dur     <= c_turn_ticks;
                        r_busy    <= 1'b1;
                        r_wheel_l <= c_wh_rev;
                        r_wheel_r <= c_wh_fwd;
                     end
                     c_cmd_right: begin
                        r_state   <= S_TURN;
                        r_dur     <= cmd_if.around ? c_uturn_ticks : c_turn_ticks;
                        r_busy    <= 1'b1;
                        r_wheel_l <= c_wh_fwd;
                        r_wheel_r <= c_wh_rev;
                     end
                     c_cmd_fwd: begin
                        r_state   <= S_FWD;
                        r_dur     <= c_fwd_ticks;
                        r_busy    <= 1'b1;
                        r_wheel_l <= c_wh_fwd;
                        r_wheel_r <= c_wh_fwd;
                     end
                     c_cmd_stop: ;
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            S_TURN, S_FWD: begin
               // Power loss takes priority over a completion on the same edge.
               if (!power) begin
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                  r_aborted <= 1'b1;
                  r_wheel_l <= c_wh_stop;
                  r_wheel_r <= c_wh_stop;
               end else if (w_tick) begin
                  r_presc <= '0;
                  r_ticks <= w_ticks_nxt;
                  if (w_ticks_nxt == r_dur) begin
                     r_state   <= S_DONE;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_wheel_l <= c_wh_stop;
                     r_wheel_r <= c_wh_stop;
                  end
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_if.cmd_ready = w_ready;
   assign cmd_if.busy      = r_busy;
   assign cmd_if.done      = r_done;
   assign cmd_if.aborted   = r_aborted;
   assign cmd_if.err       = r_err;
   assign wheel_l          = r_wheel_l;
   assign wheel_r          = r_wheel_r;

endmodule

`default_nettype wire

// File: tb/tb_turn_executor.sv
// ============================================================================
// tb_turn_executor : randomized self-checking bench for turn_executor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_turn_executor;

   localparam int TC = 4;
   localparam int TT = 3;
   localparam int UT = 6;
   localparam int FT = 2;

   localparam logic [3:0] c_stop  = 4'b0000;
   localparam logic [3:0] c_fwd   = 4'b0001;
   localparam logic [3:0] c_left  = 4'b0100;
   localparam logic [3:0] c_right = 4'b1000;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       power;
   logic [1:0] wheel_l;
   logic [1:0] wheel_r;

   int n_checks = 0;
   int n_pass   = 0;

   turn_executor_if u_if ();

   turn_executor #(
      .TICK_CYCLES (TC),
      .TURN_TICKS  (TT),
      .UTURN_TICKS (UT),
      .FWD_TICKS   (FT)
   ) u_dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .power   (power),
      .cmd_if  (u_if.slave),
      .wheel_l (wheel_l),
      .wheel_r (wheel_r)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
   endtask

   // Observed status vector: busy, done, aborted, err, cmd_ready, wheel_l, wheel_r
   function automatic logic [31:0] obs();
      return {23'd0, u_if.busy, u_if.done, u_if.aborted, u_if.err, u_if.cmd_ready,
              wheel_l, wheel_r};
   endfunction

   function automatic logic [31:0] pk(input bit b, input bit d, input bit a, input bit e,
                                      input bit r, input logic [3:0] w);
      return {23'd0, b, d, a, e, r, w};
   endfunction

   // Reference model: driven length in clock cycles (0 = no motion)
   function automatic int drive_cycles(input logic [3:0] code, input bit arnd);
      case (code)
         c_fwd:   return FT * TC;
         c_left:  return TT * TC;
         c_right: return (arnd ? UT : TT) * TC;
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] drive_wheels(input logic [3:0] code);
      case (code)
         c_fwd:   return 4'b0101;
         c_left:  return 4'b1001;
         c_right: return 4'b0110;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic run_cmd(input logic [3:0] code, input bit arnd, input int abort_at,
                          input int rst_at, input bit hold);
      int n;
      logic [3:0] w;
      n = drive_cycles(code, arnd);
      w = drive_wheels(code);
      u_if.cmd_valid = 1'b1;
      u_if.cmd       = code;
      u_if.around    = arnd;
      chk("ready_pre", {31'd0, u_if.cmd_ready}, 32'd1);
      step();
      if (hold) begin
         u_if.cmd    = c_left;
         u_if.around = 1'b1;
      end else begin
         u_if.cmd_valid = 1'b0;
         u_if.cmd       = 4'($urandom);
         u_if.around    = 1'($urandom);
      end
      if (n == 0) begin
         chk($sformatf("nonmove %b", code), obs(),
             pk(0, 0, 0, code != c_stop, 1, 4'b0000));
         u_if.cmd_valid = 1'b0;
         step();
         chk("nonmove_after", obs(), pk(0, 0, 0, 0, 1, 4'b0000));
         return;
      end
      for (int c = 1; c <= n; c++) begin
         chk($sformatf("drive %b c%0d", code, c), obs(), pk(1, 0, 0, 0, 0, w));
         if (c == abort_at) begin
            power = 1'b0;
            u_if.cmd_valid = 1'b0;
            step();
            chk($sformatf("abort c%0d", c), obs(), pk(0, 0, 1, 0, 0, 4'b0000));
            power = 1'b1;
            step();
            chk("post_abort", obs(), pk(0, 0, 0, 0, 1, 4'b0000));
            return;
         end
         if (c == rst_at) begin
            rst = 1'b1;
            u_if.cmd_valid = 1'b0;
            step();
            chk($sformatf("rst_mid c%0d", c), obs(), 32'd0);
            rst = 1'b0;
            #1;
            chk("rst_release", {31'd0, u_if.cmd_ready}, 32'd1);
            return;
         end
         step();
      end
      chk($sformatf("done %b", code), obs(), pk(0, 1, 0, 0, 0, 4'b0000));
      u_if.cmd_valid = 1'b0;
      step();
      chk("ready_again", obs(), pk(0, 0, 0, 0, 1, 4'b0000));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] code;
      bit arnd;
      int n, ab, rs, gap;

      rst = 1'b1;
      power = 1'b1;
      u_if.cmd_valid = 1'b0;
      u_if.cmd = 4'b0000;
      u_if.around = 1'b0;
      step();
      step();
      chk("reset_state", obs(), 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", {31'd0, u_if.cmd_ready}, 32'd1);

      // Directed corner cases
      run_cmd(c_left,  0, 0, 0, 0);
      run_cmd(c_right, 1, 0, 0, 0);
      run_cmd(c_right, 0, 0, 0, 0);
      run_cmd(c_fwd,   0, 0, 0, 1);
      run_cmd(c_stop,  0, 0, 0, 0);
      run_cmd(4'b0011, 0, 0, 0, 0);
      run_cmd(c_left,  0, 5, 0, 0);
      run_cmd(c_left,  0, TT * TC, 0, 0);
      run_cmd(c_left,  0, 0, 6, 0);
      run_cmd(c_left,  0, 0, 0, 0);

      // Power low while idle: nothing may be accepted
      power = 1'b0;
      u_if.cmd_valid = 1'b1;
      u_if.cmd = c_left;
      #1;
      chk("idle_nopower_ready", {31'd0, u_if.cmd_ready}, 32'd0);
      step();
      chk("idle_nopower", obs(), 32'd0);
      power = 1'b1;
      u_if.cmd_valid = 1'b0;
      #1;
      chk("power_back_ready", {31'd0, u_if.cmd_ready}, 32'd1);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: code = c_stop;
            1: code = c_fwd;
            2: code = c_left;
            3: code = c_right;
            default: begin
               do code = 4'($urandom);
               while (code == c_stop || code == c_fwd || code == c_left || code == c_right);
            end
         endcase
         arnd = 1'($urandom);
         n  = drive_cycles(code, arnd);
         ab = 0;
         rs = 0;
         if (n > 0) begin
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, n);
            else if ($urandom_range(0, 7) == 0) rs = $urandom_range(1, n);
         end
         run_cmd(code, arnd, ab, rs, 1'($urandom));
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            step();
            chk("idle_gap", obs(), pk(0, 0, 0, 0, 1, 4'b0000));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
